// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: one outstanding request to a variable-latency imem,
// valid/ready output with a single skid entry, redirect flush and fetch timeout.
module ifetch_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pcvalue,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              pc_stall,
  output logic              fetch_err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HOLD, ERR} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next, cnt_inc;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   inst_reg, inst_next;
  logic [ADDR_W-1:0]   inst_pc_reg, inst_pc_next;
  logic                inst_valid_reg, inst_valid_next;
  logic [DATA_W-1:0]   skid_data_reg, skid_data_next;
  logic [ADDR_W-1:0]   skid_pc_reg, skid_pc_next;
  logic                fetch_err_reg, fetch_err_next;
  logic [ADDR_W-1:0]   err_addr_reg, err_addr_next;
  logic                req_c, stall_c, flush_act, slot_free, expired;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      addr_reg       <= '0;
      inst_reg       <= '0;
      inst_pc_reg    <= '0;
      inst_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_pc_reg    <= '0;
      fetch_err_reg  <= 1'b0;
      err_addr_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      addr_reg       <= addr_next;
      inst_reg       <= inst_next;
      inst_pc_reg    <= inst_pc_next;
      inst_valid_reg <= inst_valid_next;
      skid_data_reg  <= skid_data_next;
      skid_pc_reg    <= skid_pc_next;
      fetch_err_reg  <= fetch_err_next;
      err_addr_reg   <= err_addr_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    addr_next       = addr_reg;
    inst_next       = inst_reg;
    inst_pc_next    = inst_pc_reg;
    inst_valid_next = inst_valid_reg;
    skid_data_next  = skid_data_reg;
    skid_pc_next    = skid_pc_reg;
    fetch_err_next  = fetch_err_reg;
    err_addr_next   = err_addr_reg;
    req_c           = 1'b0;
    stall_c         = 1'b1;

    // ERR ignores redirects; reset also keeps the PC register held
    flush_act = flush & reset & (state_reg != ERR);
    slot_free = ~inst_valid_reg | inst_ready;
    cnt_inc   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);
    expired   = (cnt_inc == CNT_MAX);

    if (inst_valid_reg && inst_ready) inst_valid_next = 1'b0;

    unique case (state_reg)
      IDLE: state_next = REQ;
      REQ: begin
        if (pcvalue[1:0] != 2'b00) begin
          if (!flush_act) begin
            fetch_err_next = 1'b1;
            err_addr_next  = pcvalue;
            state_next     = ERR;
          end
        end else begin
          req_c      = 1'b1;
          addr_next  = pcvalue;
          cnt_next   = '0;
          state_next = flush_act ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          if (flush_act) begin
            state_next = REQ;
          end else if (slot_free) begin
            inst_next       = imem_rdata;
            inst_pc_next    = addr_reg;
            inst_valid_next = 1'b1;
            stall_c         = 1'b0;
            state_next      = REQ;
          end else begin
            skid_data_next = imem_rdata;
            skid_pc_next   = addr_reg;
            state_next     = HOLD;
          end
        end else begin
          cnt_next = cnt_inc;
          if (expired) begin
            // a redirect makes the lost fetch irrelevant, so no error then
            if (flush_act) begin
              state_next = REQ;
            end else begin
              fetch_err_next = 1'b1;
              err_addr_next  = addr_reg;
              state_next     = ERR;
            end
          end else if (flush_act) begin
            state_next = DROP;
          end
        end
      end
      DROP: begin
        cnt_next = cnt_inc;
        if (imem_ack || expired) state_next = REQ;
      end
      HOLD: begin
        if (flush_act) begin
          state_next = REQ;
        end else if (inst_valid_reg && inst_ready) begin
          inst_next       = skid_data_reg;
          inst_pc_next    = skid_pc_reg;
          inst_valid_next = 1'b1;
          stall_c         = 1'b0;
          state_next      = REQ;
        end
      end
      ERR: state_next = ERR;
      default: state_next = IDLE;
    endcase

    if (flush_act) begin
      inst_valid_next = 1'b0;
      stall_c         = 1'b0;
    end
  end

  assign imem_req   = req_c;
  assign imem_addr  = req_c ? pcvalue : '0;
  assign pc_stall   = stall_c;
  assign inst       = inst_reg;
  assign inst_pc    = inst_pc_reg;
  assign inst_valid = inst_valid_reg;
  assign fetch_err  = fetch_err_reg;
  assign err_addr   = err_addr_reg;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: PC register + imem model, scoreboard of expected {inst, inst_pc}.
module tb_ifetch_unit;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pcvalue;
  logic          flush;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic [DW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic          pc_stall;
  logic          fetch_err;
  logic [AW-1:0] err_addr;

  always #5 clk = ~clk;

  ifetch_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .pcvalue(pcvalue), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .pc_stall(pc_stall),
    .fetch_err(fetch_err), .err_addr(err_addr)
  );

  int checks = 0;
  int errors = 0;

  int          cyc, pend_cnt, mem_lat, pops, stall_low;
  logic [31:0] pend_data, pend_pc, ovr_addr, ovr_data, pc_nv;
  logic        pend_stale, mem_mute, ovr_en, pc_adv, beef_seen;
  logic [63:0] sb[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic        obs_req, obs_stall, obs_valid, obs_err;
  logic [31:0] obs_addr, obs_inst, obs_pc, obs_eaddr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr_en && a == ovr_addr) return ovr_data;
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic do_reset(input logic [31:0] pc0);
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; inst_ready = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    pcvalue = pc0; pend_cnt = 0; pend_stale = 1'b0; pc_adv = 1'b0; mem_mute = 1'b0;
    ovr_en = 1'b0; mem_lat = 1; pops = 0; stall_low = 0; cyc = 0; beef_seen = 1'b0;
    sb.delete(); req_log.delete(); req_cyc.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // one clock cycle of PC register + memory + decode, then scoreboard update
  task automatic tick(input logic rdy, input logic fl, input logic [31:0] target);
    logic        delivered, del_stale;
    logic [31:0] del_pc;
    @(negedge clk);
    cyc++;
    if (pc_adv) begin pcvalue = pc_nv; pc_adv = 1'b0; end
    imem_ack = 1'b0; delivered = 1'b0; del_stale = 1'b0; del_pc = '0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_ack = 1'b1; imem_rdata = pend_data;
        delivered = 1'b1; del_pc = pend_pc; del_stale = pend_stale;
      end
    end
    inst_ready = rdy; flush = fl;
    #1;
    obs_req = imem_req; obs_addr = imem_addr; obs_stall = pc_stall; obs_valid = inst_valid;
    obs_inst = inst; obs_pc = inst_pc; obs_err = fetch_err; obs_eaddr = err_addr;
    if (!pc_stall) stall_low++;
    if (inst_valid && inst === 32'hDEADBEEF) beef_seen = 1'b1;
    if (inst_valid && inst_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got inst=%h pc=%h, required no output", inst, inst_pc);
      end else begin
        logic [63:0] exp;
        exp = sb.pop_front();
        pops++;
        if ({inst, inst_pc} !== exp) begin
          errors++;
          $display("FAIL sb_data: got inst=%h pc=%h, required inst=%h pc=%h",
                   inst, inst_pc, exp[63:32], exp[31:0]);
        end
      end
    end
    if (imem_req) begin
      req_log.push_back(imem_addr);
      req_cyc.push_back(cyc);
      if (!mem_mute) begin
        pend_cnt = mem_lat; pend_data = mem_word(imem_addr); pend_pc = imem_addr; pend_stale = 1'b0;
      end
    end
    if (fl) begin sb.delete(); pend_stale = 1'b1; end
    if (delivered && !del_stale && !fl) sb.push_back({imem_rdata, del_pc});
    if (!pc_stall) begin pc_adv = 1'b1; pc_nv = fl ? target : pcvalue + 32'd4; end
    $display("cyc=%0d pc=%h req=%b addr=%h ack=%b rdy=%b fl=%b valid=%b inst=%h ipc=%h stall=%b err=%b",
             cyc, pcvalue, obs_req, obs_addr, imem_ack, rdy, fl, obs_valid, obs_inst, obs_pc, obs_stall, obs_err);
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; inst_ready = 1'b0; imem_ack = 1'b0; imem_rdata = '0; pcvalue = '0;
    #12;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", imem_req); end
    checks++; if (imem_addr !== '0) begin errors++; $display("FAIL rst_addr: got %h required 0", imem_addr); end
    checks++; if (inst !== '0) begin errors++; $display("FAIL rst_inst: got %h required 0", inst); end
    checks++; if (inst_pc !== '0) begin errors++; $display("FAIL rst_inst_pc: got %h required 0", inst_pc); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", inst_valid); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b required 0", fetch_err); end
    checks++; if (err_addr !== '0) begin errors++; $display("FAIL rst_err_addr: got %h required 0", err_addr); end
    checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL rst_stall: got %b required 1", pc_stall); end
  endtask

  task automatic test_back_to_back();
    do_reset(32'h0);
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, '0);
    checks++;
    if (req_log.size() < 3) begin
      errors++; $display("FAIL b2b_reqs: got %0d requests, required at least 3", req_log.size());
    end else begin
      checks++; if (req_log[0] !== 32'h0 || req_cyc[0] != 1) begin errors++;
        $display("FAIL b2b_req0: got %h@%0d required 00000000@1", req_log[0], req_cyc[0]); end
      checks++; if (req_log[1] !== 32'h4 || req_cyc[1] != 3) begin errors++;
        $display("FAIL b2b_req1: got %h@%0d required 00000004@3", req_log[1], req_cyc[1]); end
      checks++; if (req_log[2] !== 32'h8 || req_cyc[2] != 5) begin errors++;
        $display("FAIL b2b_req2: got %h@%0d required 00000008@5", req_log[2], req_cyc[2]); end
    end
    checks++; if (stall_low != 3) begin errors++; $display("FAIL b2b_stall_low: got %0d required 3", stall_low); end
    checks++; if (pops != 3) begin errors++; $display("FAIL b2b_pops: got %0d required 3", pops); end
  endtask

  task automatic test_hold();
    int bad;
    bad = 0;
    do_reset(32'h100);
    ovr_en = 1'b1; ovr_addr = 32'h104; ovr_data = 32'h0000_0013;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, '0);
      if (obs_req || !obs_stall) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_stall: got %0d bad cycles required 0", bad); end
    checks++; if (!obs_valid || obs_pc !== 32'h100) begin errors++;
      $display("FAIL hold_out: got valid=%b pc=%h required 1/00000100", obs_valid, obs_pc); end
    tick(1'b1, 1'b0, '0);
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL hold_release: got stall=%b required 0", obs_stall); end
    tick(1'b0, 1'b0, '0);
    checks++; if (!obs_valid || obs_inst !== 32'h13 || obs_pc !== 32'h104) begin errors++;
      $display("FAIL hold_skid: got valid=%b inst=%h pc=%h required 1/00000013/00000104", obs_valid, obs_inst, obs_pc); end
    checks++; if (!obs_req || obs_addr !== 32'h108) begin errors++;
      $display("FAIL hold_resume: got req=%b addr=%h required 1/00000108", obs_req, obs_addr); end
    tick(1'b1, 1'b0, '0);
    checks++; if (pops != 2) begin errors++; $display("FAIL hold_pops: got %0d required 2", pops); end
  endtask

  task automatic test_flush_drop();
    int bad, n;
    logic found;
    logic [31:0] faddr;
    bad = 0; found = 1'b0; faddr = '0; n = 0;
    do_reset(32'h10);
    ovr_en = 1'b1; ovr_addr = 32'h10; ovr_data = 32'hDEADBEEF; mem_lat = 4;
    tick(1'b1, 1'b0, '0);
    checks++; if (!obs_req || obs_addr !== 32'h10) begin errors++;
      $display("FAIL drop_req: got req=%b addr=%h required 1/00000010", obs_req, obs_addr); end
    tick(1'b1, 1'b1, 32'h40);
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL drop_flush_stall: got %b required 0", obs_stall); end
    mem_lat = 1;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b1, 1'b0, '0);
      if (obs_req) begin found = 1'b1; faddr = obs_addr; n = cyc; end
      else if (!obs_stall) bad++;
    end
    checks++; if (!found || faddr !== 32'h40 || n != 6) begin errors++;
      $display("FAIL drop_redirect: got found=%b addr=%h cyc=%0d required 1/00000040/6", found, faddr, n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL drop_stall: got %0d bad cycles required 0", bad); end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '0);
    checks++; if (pops != 1) begin errors++; $display("FAIL drop_pops: got %0d required 1", pops); end
    checks++; if (beef_seen !== 1'b0) begin errors++; $display("FAIL drop_stale_seen: got %b required 0", beef_seen); end
  endtask

  task automatic test_flush_ack();
    int n;
    n = 0;
    do_reset(32'h200);
    mem_lat = 2;
    tick(1'b1, 1'b0, '0);
    while (pend_cnt != 1 && n < 10) begin tick(1'b1, 1'b0, '0); n++; end
    checks++;
    if (n >= 10) begin
      errors++; $display("FAIL fack_wait: got no pending ack in %0d cycles, required one", n);
    end else begin
      tick(1'b1, 1'b1, 32'h80);
      checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL fack_stall: got %b required 0", obs_stall); end
      tick(1'b1, 1'b0, '0);
      checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL fack_valid: got %b required 0", obs_valid); end
      checks++; if (!obs_req || obs_addr !== 32'h80) begin errors++;
        $display("FAIL fack_req: got req=%b addr=%h required 1/00000080", obs_req, obs_addr); end
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '0);
      checks++; if (pops != 1) begin errors++; $display("FAIL fack_pops: got %0d required 1", pops); end
    end
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    do_reset(32'h20);
    mem_mute = 1'b1;
    tick(1'b1, 1'b0, '0);
    checks++; if (!obs_req || obs_addr !== 32'h20) begin errors++;
      $display("FAIL to_req: got req=%b addr=%h required 1/00000020", obs_req, obs_addr); end
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, '0);
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL to_early: got err=%b required 0", obs_err); end
    tick(1'b1, 1'b0, '0);
    checks++; if (obs_err !== 1'b1 || obs_eaddr !== 32'h20) begin errors++;
      $display("FAIL to_err: got err=%b addr=%h required 1/00000020", obs_err, obs_eaddr); end
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, (i == 2), 32'h300);
      if (obs_req || !obs_stall || !obs_err) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL to_sticky: got %0d bad cycles required 0", bad); end
  endtask

  task automatic test_misalign();
    do_reset(32'h6);
    tick(1'b1, 1'b0, '0);
    checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b required 0", obs_req); end
    tick(1'b1, 1'b0, '0);
    checks++; if (obs_err !== 1'b1 || obs_eaddr !== 32'h6) begin errors++;
      $display("FAIL mis_err: got err=%b addr=%h required 1/00000006", obs_err, obs_eaddr); end
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL mis_stall: got %b required 1", obs_stall); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL async_err: got %b required 0", fetch_err); end
    checks++; if (err_addr !== '0) begin errors++; $display("FAIL async_err_addr: got %h required 0", err_addr); end
    checks++; if (imem_req !== 1'b0 || pc_stall !== 1'b1 || inst_valid !== 1'b0) begin errors++;
      $display("FAIL async_outs: got req=%b stall=%b valid=%b required 0/1/0", imem_req, pc_stall, inst_valid); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_hold();
    test_flush_drop();
    test_flush_ack();
    test_timeout();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
